// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared types and default sizes for the matrix-vector MAC sequencer
// Purpose: controller state encoding plus the default lane count and vector length,
//          shared by matvec_ctrl and the parent that builds the FIFOs and MAC array.
// Ports:   none (package).
package matvec_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_MACS   = 8;
  localparam int DEF_VEC_LEN    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } matvec_state_t;

endpackage

// File: rtl/matvec_ctrl.sv
// rtl/matvec_ctrl.sv - sequencing controller for the matrix-vector MAC array
// Purpose: on start, clears every MAC accumulator, then drains VEC_LEN operand pairs in
//          lockstep from the per-lane A FIFOs and the shared B FIFO, drives the MAC
//          enables one cycle behind the FIFO reads and pulses done when Cout is settled.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a job; only looked at in IDLE
//   abort             synchronous cancel of a job in progress
//   a_empty, b_empty  operand FIFO empty flags (per lane / shared)
//   a_rden, b_rden    operand FIFO read enables, combinational from the empty flags
//   mac_clr           accumulator clear to every MAC
//   mac_en            accumulate enable to every MAC, registered
//   busy, done        not-idle status and one-cycle completion pulse
//   issue_cnt         operand pairs read so far in the current job
module matvec_ctrl
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_MACS   = DEF_NUM_MACS,
  parameter int VEC_LEN    = DEF_VEC_LEN
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [NUM_MACS-1:0]              a_empty,
  input  logic                             b_empty,
  output logic [NUM_MACS-1:0]              a_rden,
  output logic                             b_rden,
  output logic                             mac_clr,
  output logic [NUM_MACS-1:0]              mac_en,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(VEC_LEN+1)-1:0]     issue_cnt
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);

  if (VEC_LEN < 1 || DATA_WIDTH < 1) begin : g_param_check
    $error("matvec_ctrl: VEC_LEN and DATA_WIDTH must be at least 1");
  end

  matvec_state_t    state, state_nxt;
  logic [CNT_W-1:0] issue_cnt_q;
  logic             mac_en_q;
  logic             fire;
  logic             last_issue;

  // One read across all lanes only when every A FIFO and the B FIFO have data, so
  // the lanes can never drift apart. Abort masks the read in its own cycle.
  assign fire = (state == RUN) & ~abort & ~(|a_empty) & ~b_empty &
                (issue_cnt_q < CNT_W'(VEC_LEN));
  assign last_issue = (issue_cnt_q == CNT_W'(VEC_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_cnt_q <= '0;
      mac_en_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      // FIFO data appears one cycle after the read, so the MAC enable trails fire.
      mac_en_q <= fire;
      if (state == CLEAR) begin
        issue_cnt_q <= '0;
      end else if (fire) begin
        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nxt = CLEAR;
        CLEAR:   state_nxt = RUN;
        RUN:     if (fire && last_issue) state_nxt = DRAIN;
        DRAIN:   state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign a_rden    = {NUM_MACS{fire}};
  assign b_rden    = fire;
  assign mac_clr   = (state == CLEAR);
  assign mac_en    = {NUM_MACS{mac_en_q}};
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_matvec_ctrl.sv
// tb/tb_matvec_ctrl.sv - scoreboard bench for matvec_ctrl with FIFO and MAC models
module tb_matvec_ctrl;

  localparam int NM     = 8;
  localparam int VL     = 8;
  localparam int SUM_SQ = 204;  // 1+4+9+16+25+36+49+64

  typedef struct {
    int done_cyc;
    int fires;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          flush = 1'b0;
  logic [NM-1:0] stall = '0;
  logic [NM-1:0] a_empty, a_rden, mac_en;
  logic          b_empty, b_rden, mac_clr, busy, done;
  logic [3:0]    issue_cnt;

  logic          start1 = 1'b0;
  logic [1:0]    a_rden1, mac_en1;
  logic          b_rden1, mac_clr1, busy1, done1;
  logic [0:0]    issue_cnt1;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  int a_mem [NM][64];
  int a_wp [NM] = '{default: 0};
  int a_rp [NM] = '{default: 0};
  int a_rd [NM] = '{default: 0};
  int a_q  [NM] = '{default: 0};
  int b_mem [64];
  int b_wp = 0, b_rp = 0, b_rd = 0, b_q = 0;
  int acc  [NM] = '{default: 0};

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_fires = 0;
  int   s = 0;
  int   rd0 [NM];
  int   b_rd0 = 0;

  matvec_ctrl #(.DATA_WIDTH(8), .NUM_MACS(NM), .VEC_LEN(VL)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_empty(a_empty), .b_empty(b_empty), .a_rden(a_rden), .b_rden(b_rden),
    .mac_clr(mac_clr), .mac_en(mac_en), .busy(busy), .done(done),
    .issue_cnt(issue_cnt)
  );

  matvec_ctrl #(.DATA_WIDTH(8), .NUM_MACS(2), .VEC_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .a_empty(2'b00), .b_empty(1'b0), .a_rden(a_rden1), .b_rden(b_rden1),
    .mac_clr(mac_clr1), .mac_en(mac_en1), .busy(busy1), .done(done1),
    .issue_cnt(issue_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NM; g++) begin : g_empty
    assign a_empty[g] = (a_wp[g] == a_rp[g]) || stall[g];
  end
  assign b_empty = (b_wp == b_rp);

  // FIFO model with registered read data (one cycle latency).
  always @(posedge clk) begin
    for (int i = 0; i < NM; i++) begin
      if (flush) begin
        a_rp[i] <= a_wp[i];
      end else if (a_rden[i]) begin
        a_q[i]  <= a_mem[i][a_rp[i] % 64];
        a_rp[i] <= a_rp[i] + 1;
        a_rd[i] <= a_rd[i] + 1;
      end
    end
    if (flush) begin
      b_rp <= b_wp;
    end else if (b_rden) begin
      b_q  <= b_mem[b_rp % 64];
      b_rp <= b_rp + 1;
      b_rd <= b_rd + 1;
    end
  end

  // MAC model.
  always @(posedge clk) begin
    for (int i = 0; i < NM; i++) begin
      if (mac_clr) acc[i] <= 0;
      else if (mac_en[i]) acc[i] <= acc[i] + a_q[i] * b_q;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Lane i gets k*(i+1), B gets k, for k = 1..VL.
  task automatic fill_all();
    for (int k = 1; k <= VL; k++) begin
      for (int i = 0; i < NM; i++) begin
        a_mem[i][a_wp[i] % 64] = k * (i + 1);
        a_wp[i] = a_wp[i] + 1;
      end
      b_mem[b_wp % 64] = k;
      b_wp = b_wp + 1;
    end
  endtask

  task automatic do_flush();
    next_cyc();
    flush = 1'b1;
    next_cyc();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({"idle_", name}, int'(busy), 0);
  endtask

  task automatic nominal_job(input string name);
    fill_all();
    next_cyc();
    s = cyc;
    start = 1'b1;
    exp_q.push_back('{done_cyc: s + 11, fires: VL});
    next_cyc();
    start = 1'b0;
    @(negedge clk);
    chk({"clr_", name}, int'(mac_clr), 1);
    wait_idle(40, name);
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (mac_clr) mon_fires = 0;
            if (a_rden[0]) mon_fires++;
            if (done) begin
              if (exp_q.size() == 0) begin
                chk("unexpected_done", cyc, -1);
              end else begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", cyc, mon_e.done_cyc);
                chk("fire_count", mon_fires, mon_e.fires);
                for (int i = 0; i < NM; i++)
                  chk($sformatf("cout_lane%0d", i), acc[i], SUM_SQ * (i + 1));
              end
            end
          end
        end
      end
      begin : stimulus
        // Reset state.
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({a_rden, b_rden, mac_clr, mac_en, done}), 0);
        chk("rst_cnt", int'(issue_cnt), 0);
        next_cyc();
        rst_n = 1'b1;

        // Nominal job: done 11 cycles after start.
        nominal_job("nominal");

        // Stall: lane 3 empty for 4 cycles after the second read.
        fill_all();
        next_cyc();
        s = cyc;
        start = 1'b1;
        exp_q.push_back('{done_cyc: s + 15, fires: VL});
        next_cyc();
        start = 1'b0;
        while (cyc < s + 4) next_cyc();
        stall[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if (k > 0) next_cyc();
          @(negedge clk);
          chk("stall_a_rden", int'(a_rden), 0);
          chk("stall_b_rden", int'(b_rden), 0);
        end
        chk("stall_cnt", int'(issue_cnt), 2);
        next_cyc();
        stall[3] = 1'b0;
        wait_idle(40, "stall");

        // Abort in RUN at issue_cnt == 4.
        fill_all();
        next_cyc();
        s = cyc;
        for (int i = 0; i < NM; i++) rd0[i] = a_rd[i];
        b_rd0 = b_rd;
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        while (cyc < s + 6) next_cyc();
        abort = 1'b1;
        @(negedge clk);
        chk("abort_cnt", int'(issue_cnt), 4);
        chk("abort_a_rden", int'(a_rden), 0);
        chk("abort_b_rden", int'(b_rden), 0);
        chk("abort_inflight_en", int'(mac_en), 255);
        next_cyc();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", int'(busy), 0);
        chk("abort_no_done", int'(done), 0);
        chk("abort_en_off", int'(mac_en), 0);
        for (int i = 0; i < NM; i++)
          chk($sformatf("abort_reads_lane%0d", i), a_rd[i] - rd0[i], 4);
        chk("abort_reads_b", b_rd - b_rd0, 4);
        do_flush();
        nominal_job("after_abort");

        // start held high: back-to-back jobs, period 12; start pulse in RUN ignored.
        fill_all();
        fill_all();
        next_cyc();
        s = cyc;
        start = 1'b1;
        exp_q.push_back('{done_cyc: s + 11, fires: VL});
        exp_q.push_back('{done_cyc: s + 23, fires: VL});
        while (cyc < s + 13) next_cyc();
        start = 1'b0;
        @(negedge clk);
        chk("b2b_clr2", int'(mac_clr), 1);
        while (cyc < s + 16) next_cyc();
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        wait_idle(40, "b2b");
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("b2b_no_third", int'(busy), 0);

        // start and abort together in IDLE.
        next_cyc();
        start = 1'b1;
        abort = 1'b1;
        next_cyc();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", int'(busy), 0);
        chk("start_abort_clr", int'(mac_clr), 0);

        // Asynchronous reset mid-RUN at issue_cnt == 5.
        fill_all();
        next_cyc();
        s = cyc;
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        while (cyc < s + 7) next_cyc();
        #2;
        chk("pre_rst_cnt", int'(issue_cnt), 5);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_outs", int'({a_rden, b_rden, mac_clr, mac_en, done}), 0);
        chk("arst_cnt", int'(issue_cnt), 0);
        next_cyc();
        rst_n = 1'b1;
        do_flush();
        nominal_job("after_reset");

        // VEC_LEN = 1 build: fire in cycle 2, done in cycle 4.
        next_cyc();
        s = cyc;
        start1 = 1'b1;
        next_cyc();
        start1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
          @(negedge clk);
          chk($sformatf("v1_rden_c%0d", k), int'(b_rden1), (k == 2) ? 1 : 0);
          chk($sformatf("v1_done_c%0d", k), int'(done1), (k == 4) ? 1 : 0);
          chk($sformatf("v1_cnt_c%0d", k), int'(issue_cnt1), (k >= 3) ? 1 : 0);
          next_cyc();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
      end
    join
  end

endmodule
